// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Byte-lane decoder: {hsize, addr[1:0]} -> 32-bit lane mask and alignment flag.
// Sizes above word select all four lanes.
module ahb_byte_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] lane_mask,
  output logic       misalign
);

  always_comb begin
    lane_mask = '0;
    misalign  = 1'b0;
    case (hsize)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr;
      HSIZE_HALF: begin
        lane_mask = addr[1] ? 4'b1100 : 4'b0011;
        misalign  = addr[0];
      end
      HSIZE_WORD: begin
        lane_mask = '1;
        misalign  = |addr;
      end
      default: begin
        lane_mask = '1;
        misalign  = |addr;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable depth, wait states and write-to-read forwarding.
// Define AHB_SRAM_ERR_EN to enable the two-cycle ERROR response for bad accesses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic [2:0]  hsize_i,
  input  logic        hwrite_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic        hreadyout_o,
  output logic [31:0] hrdata_o,
  output logic        hresp_o
);

  localparam int unsigned IW    = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IW;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  logic [31:0] mem [DEPTH];

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          dp_valid, dp_write;
  logic [IW-1:0] dp_idx;
  logic [3:0]    dp_mask;

  logic          acc, acc_err, acc_misalign;
  logic [3:0]    acc_mask;
  logic [IW-1:0] acc_idx;
  logic          commit;
  logic [31:0]   rd_word;
  logic          unused_trans;

  ahb_byte_lane_dec u_lane_dec (
    .hsize     (hsize_i),
    .addr      (haddr_i[1:0]),
    .lane_mask (acc_mask),
    .misalign  (acc_misalign)
  );

  assign hreadyout_o  = (state == S_IDLE) || (state == S_ERR2);
  assign acc          = hsel_i && htrans_i[1] && hready_i && hreadyout_o;
  assign acc_idx      = haddr_i[ADDR_WIDTH-1:2];
  assign unused_trans = htrans_i[0];

`ifdef AHB_SRAM_ERR_EN
  assign acc_err = (|haddr_i[31:ADDR_WIDTH]) || acc_misalign || (hsize_i > HSIZE_WORD);
  assign hresp_o = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  logic unused_addr;
  assign unused_addr = ^{haddr_i[31:ADDR_WIDTH], acc_misalign};
  assign acc_err     = 1'b0;
  assign hresp_o     = HRESP_OKAY;
`endif

  assign commit = dp_valid && dp_write && hreadyout_o && !rst_i;

  // A read accepted while a write to the same word commits sees the new lanes.
  always_comb begin
    rd_word = mem[acc_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (commit && (dp_idx == acc_idx) && dp_mask[i])
        rd_word[8*i +: 8] = hwdata_i[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        if (acc && acc_err) begin
          state_nxt = S_ERR1;
        end else if (acc && (WS != '0)) begin
          state_nxt = S_WAIT;
          cnt_nxt   = WS;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_mask  <= '0;
      hrdata_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (hreadyout_o) begin
        dp_valid <= acc && !acc_err;
        dp_write <= hwrite_i;
        dp_idx   <= acc_idx;
        dp_mask  <= acc_mask;
      end
      if (acc && !acc_err && !hwrite_i)
        hrdata_o <= rd_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (dp_mask[i]) mem[dp_idx][8*i +: 8] <= hwdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: zero-wait and 3-wait instances against a byte-array model.
module tb_ahb_sram_slave;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic        rdy    [2];
  logic [31:0] hrdata [2];
  logic        hresp  [2];

  ahb_sram_slave #(.ADDR_WIDTH(16), .WAIT_STATES(WS0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .hsel_i(hsel[0]), .haddr_i(haddr[0]), .htrans_i(htrans[0]),
    .hsize_i(hsize[0]), .hwrite_i(hwrite[0]), .hwdata_i(hwdata[0]), .hready_i(rdy[0]),
    .hreadyout_o(rdy[0]), .hrdata_o(hrdata[0]), .hresp_o(hresp[0])
  );

  ahb_sram_slave #(.ADDR_WIDTH(16), .WAIT_STATES(WS1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .hsel_i(hsel[1]), .haddr_i(haddr[1]), .htrans_i(htrans[1]),
    .hsize_i(hsize[1]), .hwrite_i(hwrite[1]), .hwdata_i(hwdata[1]), .hready_i(rdy[1]),
    .hreadyout_o(rdy[1]), .hrdata_o(hrdata[1]), .hresp_o(hresp[1])
  );

  // Model: byte-addressed memory plus the one outstanding data phase per DUT.
  logic [7:0]  mb      [2][65536];
  bit          dp_v    [2];
  bit          dp_rd   [2];
  bit          dp_err  [2];
  logic [31:0] dp_wd   [2];
  logic [31:0] dp_exp  [2];
  logic [31:0] last_rd [2];
  int          dp_low  [2];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  function automatic bit is_err(logic [31:0] a, logic [2:0] sz);
`ifdef AHB_SRAM_ERR_EN
    return (a[31:16] != 16'h0) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
           (sz == 3'd2 && a[1:0] != 2'b00);
`else
    return (a === 32'hx) && (sz === 3'hx);
`endif
  endfunction

  // One bus cycle boundary: finish the current data phase, then present a new address phase.
  task automatic step(int k, bit sel, logic [1:0] tr, logic [31:0] a, logic [2:0] sz,
                      bit wr, logic [31:0] wd);
    int guard = 0;
    bit done  = 0;
    while (!done) begin
      @(negedge clk);
      hwdata[k] = dp_v[k] ? dp_wd[k] : $urandom;
      if (dp_v[k]) begin
        chk("hresp", k, 32'(hresp[k]), 32'(dp_err[k]));
        if (!rdy[k]) dp_low[k]++;
        else begin
          chk("wait_cycles", k, dp_low[k], dp_err[k] ? 1 : (k == 0 ? WS0 : WS1));
          if (dp_rd[k] && !dp_err[k]) last_rd[k] = dp_exp[k];
          dp_v[k] = 0;
        end
      end else begin
        chk("idle_ready", k, 32'(rdy[k]), 32'd1);
        chk("idle_resp", k, 32'(hresp[k]), 32'd0);
      end
      if (rdy[k]) begin
        chk("hrdata", k, hrdata[k], last_rd[k]);
        done = 1;
      end else if (++guard > 40) begin
        chk("ready_timeout", k, 32'(rdy[k]), 32'd1);
        done = 1;
      end
    end
    hsel[k] = sel; htrans[k] = tr; haddr[k] = a; hsize[k] = sz; hwrite[k] = wr;
    if (sel && tr[1]) begin
      dp_v[k] = 1; dp_rd[k] = !wr; dp_wd[k] = wd; dp_low[k] = 0; dp_err[k] = is_err(a, sz);
      if (!dp_err[k]) begin
        int es   = (sz > 3'd2) ? 2 : int'(sz);
        int n    = 1 << es;
        int base = int'(a[15:0]) & ~(n - 1);
        int w    = int'(a[15:2]) * 4;
        if (wr) for (int i = 0; i < n; i++) mb[k][base+i] = wd[8*((base+i)%4) +: 8];
        else dp_exp[k] = {mb[k][w+3], mb[k][w+2], mb[k][w+1], mb[k][w]};
      end
    end
  endtask

  task automatic idle(int k);
    step(k, 0, 2'd0, 32'h0, 3'd0, 0, 32'h0);
  endtask

  task automatic run(int k);
    logic [7:0] sv [4];
    for (int w = 0; w < 256; w++) step(k, 1, 2'd2, 32'(w*4), 3'd2, 1, $urandom);

    step(k, 1, 2'd2, 32'h100, 3'd2, 1, 32'hDEADBEEF);
    step(k, 1, 2'd2, 32'h100, 3'd2, 0, 32'h0);
    idle(k);
    chk("lit_deadbeef", k, last_rd[k], 32'hDEADBEEF);

    step(k, 1, 2'd2, 32'h100, 3'd2, 1, 32'h11223344);
    step(k, 1, 2'd2, 32'h101, 3'd0, 1, 32'hFFFFA5FF);
    step(k, 1, 2'd3, 32'h100, 3'd2, 0, 32'h0);
    idle(k);
    chk("lit_byte_fwd", k, last_rd[k], 32'h1122A544);

    step(k, 1, 2'd2, 32'h300, 3'd2, 1, 32'h55667788);
    step(k, 1, 2'd2, 32'h302, 3'd1, 1, 32'hCAFE1234);
    step(k, 1, 2'd2, 32'h300, 3'd2, 0, 32'h0);
    idle(k);
    chk("lit_half", k, last_rd[k], 32'hCAFE7788);

    step(k, 1, 2'd2, 32'h200, 3'd2, 1, 32'h0BADF00D);
    idle(k);
    step(k, 1, 2'd2, 32'h200, 3'd2, 0, 32'h0);
    idle(k);
    chk("lit_rd200", k, last_rd[k], 32'h0BADF00D);

    if (k == 1) begin
      for (int i = 0; i < 4; i++) sv[i] = mb[k][32'h240 + i];
      step(k, 1, 2'd2, 32'h240, 3'd2, 1, 32'h5A5AC3C3);
      for (int i = 0; i < 4; i++) mb[k][32'h240 + i] = sv[i];
      @(negedge clk);
      hwdata[k] = dp_wd[k];
      chk("rst_wait_low", k, 32'(rdy[k]), 32'd0);
      hsel[k] = 0; htrans[k] = 2'd0; rst[k] = 1;
      @(negedge clk);
      rst[k] = 0;
      chk("rst_ready", k, 32'(rdy[k]), 32'd1);
      chk("rst_resp", k, 32'(hresp[k]), 32'd0);
      chk("rst_rdata", k, hrdata[k], 32'h0);
      dp_v[k] = 0; last_rd[k] = 32'h0;
      step(k, 1, 2'd2, 32'h240, 3'd2, 0, 32'h0);
      idle(k);
      chk("rst_no_write", k, last_rd[k], {sv[3], sv[2], sv[1], sv[0]});
    end

`ifdef AHB_SRAM_ERR_EN
    step(k, 1, 2'd2, 32'h0, 3'd2, 1, 32'h13579BDF);
    step(k, 1, 2'd2, 32'h0001_0000, 3'd2, 1, 32'hFFFFFFFF);
    chk("err_flag_hi", k, 32'(dp_err[k]), 32'd1);
    step(k, 1, 2'd2, 32'h102, 3'd2, 0, 32'h0);
    chk("err_flag_mis", k, 32'(dp_err[k]), 32'd1);
    step(k, 1, 2'd2, 32'h0, 3'd2, 0, 32'h0);
    idle(k);
    chk("err_no_write", k, last_rd[k], 32'h13579BDF);
`endif

    for (int n = 0; n < 600; n++) begin
      int          kind = $urandom_range(0, 9);
      logic [15:0] hi   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
      logic [31:0] a    = {hi, 6'h0, 10'($urandom_range(0, 1023))};
      logic [2:0]  sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                      : 3'($urandom_range(0, 2));
      case (kind)
        0:       step(k, 0, 2'd2, a, sz, 1, $urandom);
        1:       step(k, 1, 2'd0, a, sz, 1, $urandom);
        2:       step(k, 1, 2'd1, a, sz, 1, $urandom);
        default: step(k, 1, 2'($urandom_range(2, 3)), a, sz, 1'($urandom_range(0, 1)), $urandom);
      endcase
    end
    idle(k);
    idle(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1; hsel[k] = 0; haddr[k] = '0; htrans[k] = 2'd0; hsize[k] = 3'd0;
      hwrite[k] = 0; hwdata[k] = '0; dp_v[k] = 0; dp_low[k] = 0; last_rd[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 0; rst[1] = 0;
    fork
      run(0);
      run(1);
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
